aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencing controller for the iterative AES-128 encryption datapath: SubBytes, ShiftRows, MixColumns and AddRoundKey, with one shared state register and an on-the-fly key expander.
- Accepts a block through a valid/ready handshake and steps the datapath through the initial key add and NR rounds.
- Generates round index, Rcon, MixColumns bypass and register enables.
- Holds the result until the consumer accepts it.

Parameters:
- NR, 10, number of rounds (10 for AES-128). Legal range is 2..14.
- ROUND_CYCLES, 1, clock cycles per round. Allows a multi-cycle S-box path. Legal range is 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext/key on the datapath inputs is valid.
- in_ready  out  1  controller can accept a block.
- abort  in  1  synchronous abort. Return to IDLE.
- init_en  out  1  load state reg with plaintext^key and key reg with key.
- state_en  out  1  capture round output into the state reg.
- key_step  out  1  advance the key expander by one round key.
- last_round  out  1  bypass MixColumns this round.
- round_idx  out  4  current round number. 0 when not in a round.
- rcon  out  8  round constant for the current round. 0x00 when not in a round.
- busy  out  1  high in every state except IDLE.
- out_valid  in/out: out  1  state reg holds ciphertext.
- out_ready  in  1  consumer accepts ciphertext.
- blocks_done  out  16  count of completed handshakes.

Behaviour:
- Clocking and reset: single clock, clk. Synchronous active-high reset, rst. All state updates on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, busy=0, init_en=0, state_en=0, key_step=0, last_round=0, round_idx=0, rcon=0x00, out_valid=0, blocks_done=0. Internal round_cnt=0, sub_cnt=0, rcon_reg=0x01.
- States: IDLE, INIT, ROUND, HOLD.
- IDLE:
  - in_ready=1.
  - in_valid=1 → INIT next cycle.
  - No other output active.
- INIT (exactly 1 cycle):
  - init_en=1.
  - round_cnt←1, sub_cnt←0, rcon_reg←0x01.
  - Next state: ROUND.
- ROUND:
  - round_idx=round_cnt, rcon=rcon_reg, last_round=(round_cnt==NR).
  - sub_cnt counts 0..ROUND_CYCLES-1.
  - state_en=key_step=1 only when sub_cnt==ROUND_CYCLES-1. That cycle:
    - sub_cnt←0;
    - rcon_reg←xtime(rcon_reg), i.e. shift left by 1, XOR 0x1B if bit7 was set;
    - if round_cnt==NR → HOLD, else round_cnt+1.
- HOLD:
  - out_valid=1.
  - Outputs stay stable while out_ready=0 (backpressure of any length).
  - out_ready=1 → blocks_done+1 (wraps 0xFFFF→0x0000) and IDLE next cycle.
- Rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- Latency: the acceptance edge is cycle 0.
  - init_en is in cycle 1.
  - Round r occupies cycles 2+(r-1)·ROUND_CYCLES through 1+r·ROUND_CYCLES.
  - out_valid first rises in cycle 2+NR·ROUND_CYCLES. This is cycle 12 for the defaults.
- in_ready is high only in IDLE. There is no overlap: the next acceptance is no earlier than the cycle after the out_ready handshake.
- abort:
  - In any state: next state IDLE and all counters return to their reset values except blocks_done.
  - No state_en/init_en in the cycle following abort.
  - abort in IDLE with in_valid=1: abort wins and the block is not accepted.
- rst has priority over abort.
- rst mid-operation: return to the full reset state next cycle, including blocks_done=0.
- abort and out_ready in the same HOLD cycle: abort wins and blocks_done does not increment.
- All outputs are registered-state decodes with no combinational path from in_valid/out_ready, except in_ready, which is a state decode only.

Test Plan:
- Defaults, rst=1 for 2 cycles → every output at its listed reset value. in_valid pulse 1 cycle → init_en in cycle 1, state_en in cycles 2..11, round_idx 1..10, rcon 01,02,04,08,10,20,40,80,1B,36, last_round only in cycle 11, out_valid from cycle 12.
- FIPS-197 vector through datapath plus controller: key 000102…0F, pt 00112233445566778899AABBCCDDEEFF → ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A when out_valid=1.
- ROUND_CYCLES=3, NR=10 → state_en every 3rd cycle (cycles 4,7,…,31), out_valid at cycle 32, round_idx constant across each 3-cycle group.
- Hold out_ready=0 for 20 cycles after out_valid → out_valid stays 1, in_ready=0, blocks_done unchanged. out_ready=1 → blocks_done 0→1, IDLE next cycle.
- abort in cycle 6 (round 5) → cycle 7 in IDLE, round_idx=0, rcon=0x00, no state_en. New block accepted afterwards completes normally with rcon restarting at 0x01.
- rst asserted in HOLD after 3 completed blocks → blocks_done=0, out_valid=0, in_ready=1 next cycle. Simultaneous abort+out_ready in HOLD → blocks_done unchanged.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// Handshake and control bundle between the AES round controller and its datapath/host.
// The controller drives the "slave" side and the host/datapath drives the "master" side.
interface aes_round_ctrl_if;
  localparam int unsigned RIDX_W = 4;
  localparam int unsigned RCON_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic              init_en;
  logic              state_en;
  logic              key_step;
  logic              last_round;
  logic [RIDX_W-1:0] round_idx;
  logic [RCON_W-1:0] rcon;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  blocks_done;

  modport master (
    output in_valid, abort, out_ready,
    input  in_ready, init_en, state_en, key_step, last_round,
    input  round_idx, rcon, busy, out_valid, blocks_done
  );

  modport slave (
    input  in_valid, abort, out_ready,
    output in_ready, init_en, state_en, key_step, last_round,
    output round_idx, rcon, busy, out_valid, blocks_done
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for an iterative AES datapath: initial key add, NR rounds,
// round index / Rcon / MixColumns bypass generation and result hold until accepted.
module aes_round_ctrl #(
  parameter int unsigned NR           = 10,
  parameter int unsigned ROUND_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RCON_W = 8;
  localparam int unsigned BLK_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    round_cnt_q, round_cnt_d;
  logic [CNT_W-1:0]    sub_cnt_q, sub_cnt_d;
  logic [RCON_W-1:0]   rcon_q, rcon_d;
  logic [BLK_W-1:0]    blocks_q, blocks_d;
  logic                round_end;
  logic                final_round;

  // Last sub-cycle of a round: the datapath result is captured and the key advances.
  assign round_end   = (state_q == S_ROUND) && (sub_cnt_q == CNT_W'(ROUND_CYCLES - 1));
  assign final_round = (round_cnt_q == CNT_W'(NR));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.in_valid) state_d = S_INIT;
        S_INIT:  state_d = S_ROUND;
        S_ROUND: if (round_end && final_round) state_d = S_HOLD;
        S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Round/sub-cycle/Rcon/block counters
  always_comb begin
    round_cnt_d = round_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    rcon_d      = rcon_q;
    blocks_d    = blocks_q;
    if (bus.abort) begin
      round_cnt_d = '0;
      sub_cnt_d   = '0;
      rcon_d      = RCON_W'(8'h01);
    end else begin
      case (state_q)
        S_INIT: begin
          round_cnt_d = CNT_W'(1);
          sub_cnt_d   = '0;
          rcon_d      = RCON_W'(8'h01);
        end
        S_ROUND: begin
          if (round_end) begin
            sub_cnt_d = '0;
            rcon_d    = {rcon_q[RCON_W-2:0], 1'b0} ^ (rcon_q[RCON_W-1] ? RCON_W'(8'h1B) : '0);
            if (!final_round) round_cnt_d = round_cnt_q + CNT_W'(1);
          end else begin
            sub_cnt_d = sub_cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            blocks_d    = blocks_q + BLK_W'(1);
            round_cnt_d = '0;
            rcon_d      = RCON_W'(8'h01);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt_q <= '0;
      sub_cnt_q   <= '0;
      rcon_q      <= RCON_W'(8'h01);
      blocks_q    <= '0;
    end else begin
      round_cnt_q <= round_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      rcon_q      <= rcon_d;
      blocks_q    <= blocks_d;
    end
  end

  // Output decode from registered state only
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.init_en    = 1'b0;
    bus.state_en   = 1'b0;
    bus.key_step   = 1'b0;
    bus.last_round = 1'b0;
    bus.round_idx  = '0;
    bus.rcon       = '0;
    bus.busy       = 1'b0;
    bus.out_valid  = 1'b0;
    case (state_q)
      S_IDLE: bus.in_ready = 1'b1;
      S_INIT: begin
        bus.init_en = 1'b1;
        bus.busy    = 1'b1;
      end
      S_ROUND: begin
        bus.busy       = 1'b1;
        bus.round_idx  = round_cnt_q;
        bus.rcon       = rcon_q;
        bus.last_round = final_round;
        bus.state_en   = round_end;
        bus.key_step   = round_end;
      end
      S_HOLD: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.blocks_done = blocks_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized scoreboard bench for aes_round_ctrl: two instances (1 and 3 cycles per round),
// a per-cycle reference of the expected control outputs and a queue of expected events.
module tb_aes_round_ctrl;
  localparam int unsigned NR0 = 10;
  localparam int unsigned RC0 = 1;
  localparam int unsigned NR1 = 10;
  localparam int unsigned RC1 = 3;
  localparam int RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  typedef struct {
    int kind;   // 0 init, 1 round step, 2 result valid
    int cyc;
    int rnd;
    int rcv;
    bit last;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_ctrl_if if0 ();
  aes_round_ctrl_if if1 ();

  aes_round_ctrl #(.NR(NR0), .ROUND_CYCLES(RC0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  aes_round_ctrl #(.NR(NR1), .ROUND_CYCLES(RC1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic in_valid_d [2];
  logic abort_d    [2];
  logic out_ready_d[2];

  assign if0.in_valid  = in_valid_d[0];
  assign if0.abort     = abort_d[0];
  assign if0.out_ready = out_ready_d[0];
  assign if1.in_valid  = in_valid_d[1];
  assign if1.abort     = abort_d[1];
  assign if1.out_ready = out_ready_d[1];

  logic        init_s [2], se_s [2], ks_s [2], last_s [2], busy_s [2], rdy_s [2], ov_s [2];
  logic [3:0]  ridx_s [2];
  logic [7:0]  rcon_s [2];
  logic [15:0] bd_s   [2];

  assign init_s[0] = if0.init_en;    assign init_s[1] = if1.init_en;
  assign se_s[0]   = if0.state_en;   assign se_s[1]   = if1.state_en;
  assign ks_s[0]   = if0.key_step;   assign ks_s[1]   = if1.key_step;
  assign last_s[0] = if0.last_round; assign last_s[1] = if1.last_round;
  assign busy_s[0] = if0.busy;       assign busy_s[1] = if1.busy;
  assign rdy_s[0]  = if0.in_ready;   assign rdy_s[1]  = if1.in_ready;
  assign ov_s[0]   = if0.out_valid;  assign ov_s[1]   = if1.out_valid;
  assign ridx_s[0] = if0.round_idx;  assign ridx_s[1] = if1.round_idx;
  assign rcon_s[0] = if0.rcon;       assign rcon_s[1] = if1.rcon;
  assign bd_s[0]   = if0.blocks_done; assign bd_s[1]  = if1.blocks_done;

  ev_t exp_q [2][$];
  int  n_chk  = 0;
  int  n_pass = 0;

  function automatic int nr_of(int d); return (d == 0) ? int'(NR0) : int'(NR1); endfunction
  function automatic int rc_of(int d); return (d == 0) ? int'(RC0) : int'(RC1); endfunction

  task automatic check(string name, int d, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d @%0t: got 0x%0h expected 0x%0h", name, d, $time, act, exp);
  endtask

  // Monitor: per-cycle reference of the outputs plus event scoreboard
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int MNR = (g == 0) ? int'(NR0) : int'(NR1);
    localparam int MRC = (g == 0) ? int'(RC0) : int'(RC1);
    int cyc;
    bit active;
    bit ov_prev;
    int bd_model;

    always @(negedge clk) begin
      ev_t      e;
      int       ek;
      int       er;
      bit       se;
      bit [6:0] ctl_exp;
      int       ridx_exp;
      int       rcon_exp;
      if (rst) begin
        cyc = 0; active = 0; ov_prev = 0; bd_model = 0;
        exp_q[g].delete();
      end else begin
        cyc++;
        ridx_exp = 0;
        rcon_exp = 0;
        if (!active)                  ctl_exp = 7'b0000010;
        else if (cyc == 1)            ctl_exp = 7'b1000100;
        else if (cyc <= 1 + MNR*MRC) begin
          er = (cyc - 2) / MRC + 1;
          se = ((cyc - 1) % MRC) == 0;
          ctl_exp  = {1'b0, se, se, (er == MNR), 1'b1, 1'b0, 1'b0};
          ridx_exp = er;
          rcon_exp = RCON_TBL[er-1];
        end else                      ctl_exp = 7'b0000101;
        check("ctrl", g, {init_s[g], se_s[g], ks_s[g], last_s[g], busy_s[g], rdy_s[g], ov_s[g]},
              ctl_exp);
        check("round_idx", g, ridx_s[g], ridx_exp);
        check("rcon", g, rcon_s[g], rcon_exp);
        check("blocks_done", g, bd_s[g], bd_model);

        ek = init_s[g] ? 0 : se_s[g] ? 1 : (ov_s[g] && !ov_prev) ? 2 : -1;
        if (ek >= 0) begin
          if (exp_q[g].size() == 0) check("unexpected_event", g, ek, -1);
          else begin
            e = exp_q[g].pop_front();
            check("ev_kind", g, ek, e.kind);
            check("ev_cycle", g, cyc, e.cyc);
            if (ek == 1) begin
              check("ev_round", g, ridx_s[g], e.rnd);
              check("ev_rcon", g, rcon_s[g], e.rcv);
              check("ev_last", g, last_s[g], e.last);
            end
          end
        end
        ov_prev = ov_s[g];

        if (abort_d[g]) begin
          active = 0;
          exp_q[g].delete();
        end else if (active && cyc > 1 + MNR*MRC && out_ready_d[g]) begin
          active   = 0;
          bd_model = (bd_model + 1) & 16'hFFFF;
        end else if (!active && in_valid_d[g]) begin
          active = 1;
          cyc    = 0;
        end
      end
    end
  end

  // Present a block for one cycle from IDLE and predict its events
  task automatic send(int d);
    ev_t e;
    in_valid_d[d] = 1'b1;
    if (rdy_s[d] && !abort_d[d]) begin
      e = '{kind: 0, cyc: 1, rnd: 0, rcv: 0, last: 1'b0};
      exp_q[d].push_back(e);
      for (int r = 1; r <= nr_of(d); r++) begin
        e = '{kind: 1, cyc: 1 + r*rc_of(d), rnd: r, rcv: RCON_TBL[r-1], last: (r == nr_of(d))};
        exp_q[d].push_back(e);
      end
      e = '{kind: 2, cyc: 2 + nr_of(d)*rc_of(d), rnd: 0, rcv: 0, last: 1'b0};
      exp_q[d].push_back(e);
    end
    @(posedge clk); #1;
    in_valid_d[d] = 1'b0;
  endtask

  task automatic wait_ov(int d);
    int n;
    n = 0;
    while (!ov_s[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid_seen", d, ov_s[d], 1);
  endtask

  task automatic run_block(int d, int bp);
    send(d);
    wait_ov(d);
    repeat (bp) begin @(posedge clk); #1; end
    out_ready_d[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_d[d] = 1'b0;
  endtask

  task automatic abort_at(int d, int k);
    repeat (k) begin @(posedge clk); #1; end
    abort_d[d] = 1'b1;
    @(posedge clk); #1;
    abort_d[d] = 1'b0;
  endtask

  task automatic rand_block(int d);
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    if ($urandom_range(0, 3) == 0) begin
      send(d);
      abort_at(d, $urandom_range(0, nr_of(d)*rc_of(d) + 2));
    end else begin
      run_block(d, $urandom_range(0, 6));
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid_d[i] = 1'b0; abort_d[i] = 1'b0; out_ready_d[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_block(0, 0);
    run_block(0, 20);
    // abort during round 5
    send(0);
    abort_at(0, 5);
    run_block(0, 0);
    // abort wins over a simultaneous in_valid in IDLE
    in_valid_d[0] = 1'b1; abort_d[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_d[0] = 1'b0; abort_d[0] = 1'b0;
    @(posedge clk); #1;
    // abort together with out_ready in HOLD
    send(0);
    wait_ov(0);
    @(posedge clk); #1;
    abort_d[0] = 1'b1; out_ready_d[0] = 1'b1;
    @(posedge clk); #1;
    abort_d[0] = 1'b0; out_ready_d[0] = 1'b0;

    for (int i = 0; i < 8; i++) rand_block(0);
    // synchronous reset while holding a result
    repeat (3) run_block(0, $urandom_range(0, 3));
    send(0);
    wait_ov(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_block(0, 0);

    run_block(1, 0);
    run_block(1, 5);
    send(1);
    abort_at(1, 13);
    for (int i = 0; i < 5; i++) rand_block(1);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drain", 0, exp_q[0].size(), 0);
    check("queue_drain", 1, exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
